// File: rtl/ps2_rx_fifo_axi.sv
// rtl/ps2_rx_fifo_axi.sv - PS/2 receiver with scan-code FIFO behind an AXI4 slave register port
//
// Purpose: samples an asynchronous PS/2 device, checks each 11-bit frame and
// queues good bytes in a FIFO that software drains over a single-beat AXI4 slave.
// Registers (offset [3:0]): 0x0 DATA (RO, pops), 0x4 STATUS (RO), 0x8 CTRL (RW),
// 0xC..0xF answer SLVERR.
// Optional feature macro: PS2_IRQ_EN (level interrupt; without it irq is tied 0).
//
// Ports:
//   clock, resetn           system clock, asynchronous active-low reset
//   ps2_clk, ps2_dat        asynchronous PS/2 device clock and data
//   irq                     registered level interrupt
//   io_slave_aw*/w*/b*      AXI write address / data / response channels
//   io_slave_ar*/r*         AXI read address / data channels
module ps2_rx_fifo_axi #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic        irq,
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [63:0] io_slave_wdata,
  input  logic [7:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [63:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_BRESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}          rstate_t;

  // ---------------------------------------------------------------- receiver
  logic [2:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;

  logic w_sample, w_bit, w_frame_done, w_frame_ok, w_frame_bad, w_timeout;

  // Data goes through one stage fewer so it lines up with the clock stage
  // that first shows the low level.
  assign w_sample     = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_bit        = r_dat_sync[1];
  assign w_frame_done = w_sample && (r_bit_cnt == 4'd10);
  assign w_frame_ok   = w_frame_done && w_bit && (^{r_shift, r_par});
  assign w_frame_bad  = w_frame_done && !(w_bit && (^{r_shift, r_par}));
  assign w_timeout    = !w_sample && (r_bit_cnt != 4'd0) &&
                        (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_clk_sync <= 3'b111;
      r_dat_sync <= 2'b11;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'd0;
      r_par      <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_dat};
      if (w_sample) begin
        r_to_cnt <= '0;
        if (r_bit_cnt == 4'd0) begin
          // A high start bit is line noise, not a frame.
          if (!w_bit) r_bit_cnt <= 4'd1;
        end else if (r_bit_cnt <= 4'd8) begin
          r_shift   <= {w_bit, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else if (r_bit_cnt == 4'd9) begin
          r_par     <= w_bit;
          r_bit_cnt <= 4'd10;
        end else begin
          r_bit_cnt <= 4'd0;
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (w_timeout) begin
          r_bit_cnt <= 4'd0;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  // -------------------------------------------------------------- AXI decode
  logic          r_arready, r_rvalid, r_rlast;
  logic [1:0]    r_rresp;
  logic [63:0]   r_rdata;
  logic [3:0]    r_rid;
  rstate_t       r_rstate;

  logic          r_awready, r_wready, r_bvalid;
  logic [1:0]    r_bresp;
  logic [3:0]    r_bid;
  wstate_t       r_wstate;
  logic          r_aw_held, r_w_held;
  logic [1:0]    r_awaddr_q;
  logic [3:0]    r_awid_q;
  logic [2:0]    r_wdata_q;
  logic          r_wstrb0_q;

  logic          w_ar_hs, w_aw_hs, w_w_hs, w_do_write, w_ctrl_wr;
  logic [1:0]    w_wr_off;
  logic [3:0]    w_wr_id;
  logic [2:0]    w_wr_data;
  logic          w_wr_strb0;

  assign w_ar_hs    = io_slave_arvalid && r_arready;
  assign w_aw_hs    = io_slave_awvalid && r_awready;
  assign w_w_hs     = io_slave_wvalid && r_wready;
  // The register write fires in the cycle the second of the two beats lands,
  // taking the held half from the capture registers and the other half live.
  assign w_do_write = (r_wstate != W_BRESP) && (r_aw_held || w_aw_hs) &&
                      (r_w_held || w_w_hs);
  assign w_wr_off   = r_aw_held ? r_awaddr_q : io_slave_awaddr[3:2];
  assign w_wr_id    = r_aw_held ? r_awid_q   : io_slave_awid;
  assign w_wr_data  = r_w_held  ? r_wdata_q  : io_slave_wdata[2:0];
  assign w_wr_strb0 = r_w_held  ? r_wstrb0_q : io_slave_wstrb[0];
  assign w_ctrl_wr  = w_do_write && (w_wr_off == 2'd2) && w_wr_strb0;

  // -------------------------------------------------------------------- FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [8:0]    r_count;
  logic          r_ovf, r_ferr;
  logic          w_irq_en;

  logic w_nonempty, w_full, w_pop, w_push_ok, w_flush;

  assign w_nonempty = (r_count != 9'd0);
  assign w_full     = (r_count == 9'(FIFO_DEPTH));
  assign w_pop      = w_ar_hs && (io_slave_araddr[3:2] == 2'd0) && w_nonempty;
  // When full, a simultaneous pop frees the slot being written.
  assign w_push_ok  = w_frame_ok && (!w_full || w_pop);
  assign w_flush    = w_ctrl_wr && w_wr_data[1];

  always_ff @(posedge clock) begin
    if (w_push_ok && !w_flush) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 9'd0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 9'd0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {8'd0, w_push_ok} - {8'd0, w_pop};
    end
  end

  // Sticky flags: a new error in the clearing cycle is kept.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_ctrl_wr && w_wr_data[2]) begin
        r_ovf  <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (w_frame_ok && w_full && !w_pop) r_ovf  <= 1'b1;
      if (w_frame_bad || w_timeout)       r_ferr <= 1'b1;
    end
  end

`ifdef PS2_IRQ_EN
  logic r_irq_en, r_irq;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= w_wr_data[0];
      r_irq <= r_irq_en && (w_nonempty || r_ovf);
    end
  end
  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign irq      = 1'b0;
`endif

  // --------------------------------------------------------------- read path
  logic [31:0] w_rd_val;
  logic        w_rd_err;

  always_comb begin
    w_rd_val = 32'd0;
    w_rd_err = 1'b0;
    case (io_slave_araddr[3:2])
      2'd0:    if (w_nonempty) w_rd_val = {23'd0, 1'b1, r_mem[r_rd_ptr]};
      2'd1:    w_rd_val = {20'd0, w_irq_en, r_ferr, r_ovf, r_count};
      2'd2:    w_rd_val = {31'd0, w_irq_en};
      default: w_rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= 64'd0;
      r_rid     <= 4'd0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (io_slave_arvalid) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rlast   <= 1'b1;
            r_rid     <= io_slave_arid;
            r_rdata   <= {w_rd_val, w_rd_val};
            r_rresp   <= w_rd_err ? 2'b10 : 2'b00;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (io_slave_rready) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------- write path
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wstate   <= W_IDLE;
      r_awready  <= 1'b1;
      r_wready   <= 1'b1;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_bid      <= 4'd0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr_q <= 2'd0;
      r_awid_q   <= 4'd0;
      r_wdata_q  <= 3'd0;
      r_wstrb0_q <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE, W_WAIT: begin
          if (w_aw_hs) begin
            r_aw_held  <= 1'b1;
            r_awready  <= 1'b0;
            r_awaddr_q <= io_slave_awaddr[3:2];
            r_awid_q   <= io_slave_awid;
          end
          if (w_w_hs) begin
            r_w_held   <= 1'b1;
            r_wready   <= 1'b0;
            r_wdata_q  <= io_slave_wdata[2:0];
            r_wstrb0_q <= io_slave_wstrb[0];
          end
          if (w_do_write) begin
            r_wstate  <= W_BRESP;
            r_bvalid  <= 1'b1;
            r_bresp   <= (w_wr_off == 2'd3) ? 2'b10 : 2'b00;
            r_bid     <= w_wr_id;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
          end else if (w_aw_hs || w_w_hs) begin
            r_wstate <= W_WAIT;
          end
        end
        W_BRESP: begin
          if (io_slave_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign io_slave_arready = r_arready;
  assign io_slave_rvalid  = r_rvalid;
  assign io_slave_rlast   = r_rlast;
  assign io_slave_rresp   = r_rresp;
  assign io_slave_rdata   = r_rdata;
  assign io_slave_rid     = r_rid;
  assign io_slave_awready = r_awready;
  assign io_slave_wready  = r_wready;
  assign io_slave_bvalid  = r_bvalid;
  assign io_slave_bresp   = r_bresp;
  assign io_slave_bid     = r_bid;

  // Burst attributes and upper address/data lanes carry no meaning here.
  logic w_unused_ok;
  assign w_unused_ok = ^{io_slave_awaddr[31:4], io_slave_awaddr[1:0],
                         io_slave_araddr[31:4], io_slave_araddr[1:0],
                         io_slave_awlen, io_slave_awsize, io_slave_awburst,
                         io_slave_arlen, io_slave_arsize, io_slave_arburst,
                         io_slave_wdata[63:3], io_slave_wstrb[7:1],
                         io_slave_wlast, w_wr_data[0]};

endmodule

// File: tb/tb_ps2_rx_fifo_axi.sv
// tb/tb_ps2_rx_fifo_axi.sv - directed self-checking bench for ps2_rx_fifo_axi
module tb_ps2_rx_fifo_axi;

  localparam int DEPTH = 8;
  localparam int TOUT  = 4096;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        irq;
  logic        awready, awvalid = 1'b0;
  logic [31:0] awaddr = '0;
  logic [3:0]  awid = '0;
  logic        wready, wvalid = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        bready = 1'b0, bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arready, arvalid = 1'b0;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic        rready = 1'b0, rvalid, rlast;
  logic [1:0]  rresp;
  logic [63:0] rdata;
  logic [3:0]  rid;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] d;
  logic [1:0]  rsp;
  logic [3:0]  id_o;
  logic        last_o;

  always #5 clock = ~clock;

  ps2_rx_fifo_axi #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
    .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .irq(irq),
    .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(8'd0), .io_slave_awsize(3'd3),
    .io_slave_awburst(2'd1),
    .io_slave_wready(wready), .io_slave_wvalid(wvalid), .io_slave_wdata(wdata),
    .io_slave_wstrb(wstrb), .io_slave_wlast(1'b1),
    .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp),
    .io_slave_bid(bid),
    .io_slave_arready(arready), .io_slave_arvalid(arvalid), .io_slave_araddr(araddr),
    .io_slave_arid(arid), .io_slave_arlen(8'd0), .io_slave_arsize(3'd3),
    .io_slave_arburst(2'd1),
    .io_slave_rready(rready), .io_slave_rvalid(rvalid), .io_slave_rresp(rresp),
    .io_slave_rdata(rdata), .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  // Bits go out LSB first; data changes while ps2_clk is high.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      repeat (10) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (10) @(negedge clock);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (12) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    send_bits({1'b1, par, b, 1'b0}, 11);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id,
                          output logic [63:0] dat, output logic [1:0] resp,
                          output logic [3:0] rid_o, output logic lst);
    int cnt;
    @(negedge clock);
    arvalid = 1'b1; araddr = addr; arid = id;
    cnt = 0;
    while (!arready && cnt < 50) begin @(negedge clock); cnt++; end
    if (cnt >= 50) bound_fail("arready_wait");
    @(posedge clock);
    @(negedge clock);
    arvalid = 1'b0;
    check("rvalid_one_cycle", {63'd0, rvalid}, 64'd1);
    dat = rdata; resp = rresp; rid_o = rid; lst = rlast;
    rready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [63:0] dat,
                           input logic [7:0] strb, input logic [3:0] id,
                           input logic w_first, output logic [1:0] resp,
                           output logic [3:0] bid_o);
    int cnt;
    @(negedge clock);
    awaddr = addr; awid = id; wdata = dat; wstrb = strb;
    if (w_first) begin
      wvalid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      wvalid = 1'b0;
      repeat (2) @(negedge clock);
      awvalid = 1'b1;
      cnt = 0;
      while (!awready && cnt < 50) begin @(negedge clock); cnt++; end
      if (cnt >= 50) bound_fail("awready_wait");
    end else begin
      awvalid = 1'b1; wvalid = 1'b1;
      cnt = 0;
      while (!(awready && wready) && cnt < 50) begin @(negedge clock); cnt++; end
      if (cnt >= 50) bound_fail("aw_w_ready_wait");
    end
    @(posedge clock);
    @(negedge clock);
    awvalid = 1'b0; wvalid = 1'b0;
    cnt = 0;
    while (!bvalid && cnt < 50) begin @(negedge clock); cnt++; end
    if (cnt >= 50) bound_fail("bvalid_wait");
    resp = bresp; bid_o = bid;
    bready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_arready", {63'd0, arready}, 64'd1);
    check("rst_awready", {63'd0, awready}, 64'd1);
    check("rst_wready",  {63'd0, wready},  64'd1);
    check("rst_rvalid_bvalid_rlast_irq", {60'd0, rvalid, bvalid, rlast, irq}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_resp_ids", {52'd0, rresp, bresp, rid, bid}, 64'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    // Single good frame 0x1C, then empty read
    send_byte(8'h1C, 1'b0);
    axi_read(32'h0, 4'h5, d, rsp, id_o, last_o);
    check("data_1c", d, {32'h11C, 32'h11C});
    check("data_1c_rresp", {62'd0, rsp}, 64'd0);
    check("data_1c_rid", {60'd0, id_o}, 64'h5);
    check("data_1c_rlast", {63'd0, last_o}, 64'd1);
    axi_read(32'h0, 4'h1, d, rsp, id_o, last_o);
    check("data_empty", d, 64'd0);

    // DEPTH+1 frames: overflow
    for (int i = 0; i <= DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b0);
    axi_read(32'h4, 4'h2, d, rsp, id_o, last_o);
    check("status_full_ovf", d, {32'h208, 32'h208});
    axi_read(32'h0, 4'h3, d, rsp, id_o, last_o);
    check("data_first_of_full", d, {32'h110, 32'h110});
    axi_write(32'h8, 64'h6, 8'h01, 4'hA, 1'b0, rsp, id_o);
    check("ctrl_flush_bresp", {62'd0, rsp}, 64'd0);
    check("ctrl_flush_bid", {60'd0, id_o}, 64'hA);
    axi_read(32'h4, 4'h2, d, rsp, id_o, last_o);
    check("status_after_flush_clear", d, 64'd0);

    // Bad parity frame
    send_byte(8'h55, 1'b1);
    axi_read(32'h4, 4'h2, d, rsp, id_o, last_o);
    check("status_ferr_parity", d, {32'h400, 32'h400});
    axi_write(32'h8, 64'h4, 8'h01, 4'h6, 1'b1, rsp, id_o);
    check("ctrl_wfirst_bid", {60'd0, id_o}, 64'h6);
    axi_read(32'h4, 4'h2, d, rsp, id_o, last_o);
    check("status_after_clear", d, 64'd0);

    // Partial frame, stall past the timeout, then a clean 0xF0
    send_bits(11'b000_0000_0000, 5);
    repeat (TOUT + 10) @(negedge clock);
    send_byte(8'hF0, 1'b0);
    axi_read(32'h4, 4'h2, d, rsp, id_o, last_o);
    check("status_timeout", d, {32'h401, 32'h401});
    axi_read(32'h0, 4'h2, d, rsp, id_o, last_o);
    check("data_f0", d, {32'h1F0, 32'h1F0});
    axi_write(32'h8, 64'h4, 8'h01, 4'h0, 1'b0, rsp, id_o);

    // Unmapped offset
    axi_read(32'hC, 4'h7, d, rsp, id_o, last_o);
    check("unmapped_rresp", {62'd0, rsp}, 64'd2);
    check("unmapped_rdata", d, 64'd0);
    axi_write(32'hC, 64'h6, 8'hFF, 4'h9, 1'b0, rsp, id_o);
    check("unmapped_bresp", {62'd0, rsp}, 64'd2);

    // CTRL write with wstrb[0]=0 is ignored
    send_byte(8'h5A, 1'b0);
    axi_write(32'h8, 64'h2, 8'h02, 4'h0, 1'b0, rsp, id_o);
    axi_read(32'h4, 4'h2, d, rsp, id_o, last_o);
    check("status_strb0_ignored", d, {32'h001, 32'h001});
    axi_read(32'h0, 4'h2, d, rsp, id_o, last_o);
    check("data_5a", d, {32'h15A, 32'h15A});

`ifdef PS2_IRQ_EN
    axi_write(32'h8, 64'h1, 8'h01, 4'h0, 1'b0, rsp, id_o);
    repeat (3) @(negedge clock);
    check("irq_enabled_empty", {63'd0, irq}, 64'd0);
    send_byte(8'h2B, 1'b0);
    check("irq_on_push", {63'd0, irq}, 64'd1);
    axi_read(32'h4, 4'h2, d, rsp, id_o, last_o);
    check("status_irq_en", d, {32'h801, 32'h801});
    axi_read(32'h0, 4'h2, d, rsp, id_o, last_o);
    check("data_2b", d, {32'h12B, 32'h12B});
    repeat (2) @(negedge clock);
    check("irq_after_pop", {63'd0, irq}, 64'd0);
`else
    axi_write(32'h8, 64'h1, 8'h01, 4'h0, 1'b0, rsp, id_o);
    send_byte(8'h2B, 1'b0);
    check("irq_tied_low", {63'd0, irq}, 64'd0);
    axi_read(32'h4, 4'h2, d, rsp, id_o, last_o);
    check("status_no_irq_en", d, {32'h001, 32'h001});
    axi_read(32'h0, 4'h2, d, rsp, id_o, last_o);
    check("data_2b", d, {32'h12B, 32'h12B});
`endif

    // Reset mid-frame with a byte queued and FERR set
    send_byte(8'h44, 1'b0);
    send_byte(8'h44, 1'b1);
    send_bits(11'b000_0000_0000, 5);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("midreset_arready", {63'd0, arready}, 64'd1);
    check("midreset_irq", {63'd0, irq}, 64'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    axi_read(32'h4, 4'h2, d, rsp, id_o, last_o);
    check("status_after_reset", d, 64'd0);
    send_byte(8'h33, 1'b0);
    axi_read(32'h0, 4'h2, d, rsp, id_o, last_o);
    check("data_33_after_reset", d, {32'h133, 32'h133});
    axi_read(32'h4, 4'h2, d, rsp, id_o, last_o);
    check("status_clean_after_reset", d, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
